sram_cache_controller: RTL and testbench

- Two-way set-associative read cache between the MEM stage's memory request (ALU result address, Val_Rm store data) and the SRAM controller.
- Read hits complete in the request cycle without an SRAM access.
- Read misses fetch a 64-bit block from SRAM and allocate it. Writes are write-through, no-write-allocate.
- `ready` low freezes the pipeline exactly as `sram_ready` does today.

---
 rtl/sram_cache_controller_if.sv | 33 +++
 rtl/sram_cache_controller.sv | 167 ++++++++++++++++
 tb/tb_sram_cache_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_cache_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_cache_controller_if
// Purpose  : MEM-stage request bus plus SRAM-controller bus of the read cache.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_cache_controller_if;
  logic        r_en;
  logic        w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  // The cache serves the pipeline and drives the SRAM controller.
  modport slave (
    input  r_en, w_en, address, wdata, sram_rdata, sram_ready,
    output rdata, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );

  // Pipeline plus SRAM controller as seen from outside the cache.
  modport master (
    output r_en, w_en, address, wdata, sram_rdata, sram_ready,
    input  rdata, ready, sram_r_en, sram_w_en, sram_address, sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_cache_controller
// Purpose  : Two-way set-associative read cache in front of the SRAM
//            controller; write-through, no-write-allocate, 1-bit LRU per set.
// Revision : 1.0 - initial release
// ============================================================================
module sram_cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  wire logic               clk,
  input  wire logic               reset,
  sram_cache_controller_if.slave  bus
);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = 3 + IDX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SETS-1:0]        valid0_q;
  logic [SETS-1:0]        valid1_q;
  logic [SETS-1:0]        lru_q;
  logic [TAG_W-1:0]       tag0_q  [SETS];
  logic [TAG_W-1:0]       tag1_q  [SETS];
  logic [63:0]            data0_q [SETS];
  logic [63:0]            data1_q [SETS];

  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_off;
  logic                   w_hit0;
  logic                   w_hit1;
  logic [63:0]            w_hit_blk;
  logic [31:0]            w_hit_word;
  logic [31:0]            w_fill_word;
  logic                   w_victim;
  logic                   w_unused_addr;

  assign w_idx  = bus.address[TAG_LSB-1:3];
  assign w_tag  = bus.address[TAG_LSB+TAG_W-1:TAG_LSB];
  assign w_off  = bus.address[2];
  assign w_unused_addr = ^{bus.address[31:TAG_LSB+TAG_W], bus.address[1:0]};

  assign w_hit0      = valid0_q[w_idx] && (tag0_q[w_idx] == w_tag);
  assign w_hit1      = valid1_q[w_idx] && (tag1_q[w_idx] == w_tag);
  assign w_hit_blk   = w_hit0 ? data0_q[w_idx] : data1_q[w_idx];
  assign w_hit_word  = w_off ? w_hit_blk[63:32] : w_hit_blk[31:0];
  assign w_fill_word = w_off ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];

  // Invalid ways are filled first (way0 before way1); otherwise the LRU way.
  assign w_victim = !valid0_q[w_idx] ? 1'b0 :
                    !valid1_q[w_idx] ? 1'b1 : lru_q[w_idx];

  always_comb begin
    bus.rdata        = 32'd0;
    bus.ready        = 1'b1;
    bus.sram_r_en    = 1'b0;
    bus.sram_w_en    = 1'b0;
    bus.sram_address = 32'd0;
    bus.sram_wdata   = 32'd0;
    case (state_q)
      IDLE: begin
        if (bus.w_en) begin
          bus.ready        = 1'b0;
          bus.sram_w_en    = 1'b1;
          bus.sram_address = bus.address;
          bus.sram_wdata   = bus.wdata;
        end else if (bus.r_en) begin
          if (w_hit0 || w_hit1) begin
            bus.rdata = w_hit_word;
          end else begin
            bus.ready        = 1'b0;
            bus.sram_r_en    = 1'b1;
            bus.sram_address = bus.address & ~32'h7;
          end
        end
      end
      RD_MISS: begin
        bus.sram_r_en    = 1'b1;
        bus.sram_address = bus.address & ~32'h7;
        bus.ready        = bus.sram_ready;
        if (bus.sram_ready) begin
          bus.rdata = w_fill_word;
        end
      end
      WR: begin
        bus.sram_w_en    = 1'b1;
        bus.sram_address = bus.address;
        bus.sram_wdata   = bus.wdata;
        bus.ready        = bus.sram_ready;
      end
      default: begin
        bus.ready = 1'b1;
      end
    endcase
    // The SRAM controller is reset alongside us, so never request during reset.
    if (reset) begin
      bus.sram_r_en = 1'b0;
      bus.sram_w_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.w_en) begin
            state_q <= WR;
          end else if (bus.r_en) begin
            if (w_hit0) begin
              lru_q[w_idx] <= 1'b1;
            end else if (w_hit1) begin
              lru_q[w_idx] <= 1'b0;
            end else begin
              state_q <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (bus.sram_ready) begin
            state_q <= IDLE;
            if (!w_victim) begin
              data0_q[w_idx]  <= bus.sram_rdata;
              tag0_q[w_idx]   <= w_tag;
              valid0_q[w_idx] <= 1'b1;
              lru_q[w_idx]    <= 1'b1;
            end else begin
              data1_q[w_idx]  <= bus.sram_rdata;
              tag1_q[w_idx]   <= w_tag;
              valid1_q[w_idx] <= 1'b1;
              lru_q[w_idx]    <= 1'b0;
            end
          end
        end
        WR: begin
          if (bus.sram_ready) begin
            state_q <= IDLE;
            if (w_hit0) begin
              if (w_off) data0_q[w_idx][63:32] <= bus.wdata;
              else       data0_q[w_idx][31:0]  <= bus.wdata;
              lru_q[w_idx] <= 1'b1;
            end else if (w_hit1) begin
              if (w_off) data1_q[w_idx][63:32] <= bus.wdata;
              else       data1_q[w_idx][31:0]  <= bus.wdata;
              lru_q[w_idx] <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_cache_controller
// Purpose  : Directed and random checks of the read cache against a
//            timestamp-LRU cache model and a backing memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_cache_controller;
  logic clk;
  logic reset;
  sram_cache_controller_if bus();

  sram_cache_controller #(.SETS(64), .TAG_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: per-set entries with last-use timestamps, plus block memory.
  logic              mv [64][2];
  logic [9:0]        mt [64][2];
  logic [63:0]       md [64][2];
  int unsigned       ms [64][2];
  int unsigned       now_t = 0;
  logic [63:0]       mem [logic [15:0]];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_blk(input logic [15:0] b);
    if (mem.exists(b)) return mem[b];
    return {b, 16'hC0DE, ~b, 16'h1234};
  endfunction

  function automatic int lookup(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (mv[a[8:3]][w] && mt[a[8:3]][w] == a[18:9]) return w;
    return -1;
  endfunction

  function automatic int victim(input logic [5:0] ix);
    if (!mv[ix][0]) return 0;
    if (!mv[ix][1]) return 1;
    return (ms[ix][0] < ms[ix][1]) ? 0 : 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 1'b0;
        ms[s][w] = 0;
      end
  endtask

  task automatic do_reset();
    bus.r_en = 1'b0; bus.w_en = 1'b0; bus.address = 32'd0; bus.wdata = 32'd0;
    bus.sram_ready = 1'b0; bus.sram_rdata = 64'd0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_idle();
    bus.r_en = 1'b0; bus.w_en = 1'b0;
    #2;
    check("idle_ready", 64'(bus.ready), 64'd1);
    check("idle_rdata", 64'(bus.rdata), 64'd0);
    check("idle_sram_r_en", 64'(bus.sram_r_en), 64'd0);
    check("idle_sram_w_en", 64'(bus.sram_w_en), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input int lat);
    int w;
    logic [5:0] ix;
    logic [63:0] blk;
    logic [31:0] exp;
    ix = a[8:3];
    bus.r_en = 1'b1; bus.w_en = 1'b0; bus.address = a; bus.wdata = $urandom;
    #2;
    w = lookup(a);
    if (w >= 0) begin
      exp = a[2] ? md[ix][w][63:32] : md[ix][w][31:0];
      check("rd_hit_ready", 64'(bus.ready), 64'd1);
      check("rd_hit_rdata", 64'(bus.rdata), 64'(exp));
      check("rd_hit_sram_r_en", 64'(bus.sram_r_en), 64'd0);
      now_t++; ms[ix][w] = now_t;
      @(posedge clk); #1;
    end else begin
      check("rd_miss_ready", 64'(bus.ready), 64'd0);
      check("rd_miss_sram_r_en", 64'(bus.sram_r_en), 64'd1);
      check("rd_miss_sram_w_en", 64'(bus.sram_w_en), 64'd0);
      check("rd_miss_sram_addr", 64'(bus.sram_address), 64'(a & ~32'h7));
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
        bus.sram_rdata = {$urandom, $urandom};
        #2;
        check("rd_wait_ready", 64'(bus.ready), 64'd0);
        check("rd_wait_sram_r_en", 64'(bus.sram_r_en), 64'd1);
        check("rd_wait_sram_addr", 64'(bus.sram_address), 64'(a & ~32'h7));
      end
      @(posedge clk); #1;
      blk = mem_blk(a[18:3]);
      bus.sram_ready = 1'b1; bus.sram_rdata = blk;
      #2;
      exp = a[2] ? blk[63:32] : blk[31:0];
      check("rd_fill_ready", 64'(bus.ready), 64'd1);
      check("rd_fill_rdata", 64'(bus.rdata), 64'(exp));
      @(posedge clk); #1;
      bus.sram_ready = 1'b0; bus.sram_rdata = {$urandom, $urandom};
      w = victim(ix);
      mv[ix][w] = 1'b1; mt[ix][w] = a[18:9]; md[ix][w] = blk;
      now_t++; ms[ix][w] = now_t;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat, input logic both);
    int w;
    logic [5:0] ix;
    logic [63:0] blk;
    ix = a[8:3];
    bus.r_en = both; bus.w_en = 1'b1; bus.address = a; bus.wdata = d;
    #2;
    check("wr_ready", 64'(bus.ready), 64'd0);
    check("wr_sram_w_en", 64'(bus.sram_w_en), 64'd1);
    check("wr_sram_r_en", 64'(bus.sram_r_en), 64'd0);
    check("wr_sram_addr", 64'(bus.sram_address), 64'(a));
    check("wr_sram_wdata", 64'(bus.sram_wdata), 64'(d));
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #3;
      check("wr_wait_ready", 64'(bus.ready), 64'd0);
      check("wr_wait_sram_w_en", 64'(bus.sram_w_en), 64'd1);
      check("wr_wait_sram_r_en", 64'(bus.sram_r_en), 64'd0);
    end
    @(posedge clk); #1;
    bus.sram_ready = 1'b1;
    #2;
    check("wr_done_ready", 64'(bus.ready), 64'd1);
    @(posedge clk); #1;
    bus.sram_ready = 1'b0;
    blk = mem_blk(a[18:3]);
    if (a[2]) blk[63:32] = d; else blk[31:0] = d;
    mem[a[18:3]] = blk;
    w = lookup(a);
    if (w >= 0) begin
      if (a[2]) md[ix][w][63:32] = d; else md[ix][w][31:0] = d;
      now_t++; ms[ix][w] = now_t;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int op;
    reset = 1'b1;
    // Basic miss then zero-latency hit on the other word of the block.
    mem[16'h0080] = 64'hBBBB_BBBB_AAAA_AAAA;
    do_reset();
    #2;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_sram_addr", 64'(bus.sram_address), 64'd0);
    check("rst_sram_wdata", 64'(bus.sram_wdata), 64'd0);
    check("rst_sram_r_en", 64'(bus.sram_r_en), 64'd0);
    check("rst_sram_w_en", 64'(bus.sram_w_en), 64'd0);
    @(posedge clk); #1;
    do_read(32'h0000_0400, 5);
    do_read(32'h0000_0404, 1);
    do_idle();

    // Conflict fill in set 0: 0xC00 evicts 0x400.
    do_reset();
    do_read(32'h400, 2); do_read(32'h800, 3); do_read(32'hC00, 1);
    do_read(32'h800, 1); do_read(32'h400, 2);

    // LRU update on hit: 0x800 is evicted instead of 0x400.
    do_reset();
    do_read(32'h400, 2); do_read(32'h800, 2); do_read(32'h400, 1);
    do_read(32'hC00, 3); do_read(32'h400, 1); do_read(32'h800, 2);

    // Write hit updates the cached word; write miss does not allocate.
    do_write(32'h404, 32'h1234_5678, 3, 1'b0);
    do_read(32'h404, 1);
    do_write(32'h2000, 32'hCAFE_F00D, 2, 1'b0);
    do_read(32'h2000, 2);
    do_idle();

    // Reset during RD_MISS abandons the fill and clears every valid bit.
    do_read(32'h400, 1);
    bus.r_en = 1'b1; bus.w_en = 1'b0; bus.address = 32'h840;
    #2;
    check("rstmiss_sram_r_en", 64'(bus.sram_r_en), 64'd1);
    @(posedge clk); #3;
    check("rstmiss_wait_ready", 64'(bus.ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; bus.r_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #2;
    check("rstmiss_ready", 64'(bus.ready), 64'd1);
    check("rstmiss_sram_r_en", 64'(bus.sram_r_en), 64'd0);
    check("rstmiss_sram_w_en", 64'(bus.sram_w_en), 64'd0);
    @(posedge clk); #1;
    do_read(32'h400, 2);

    // r_en and w_en together behave as a write with no allocation.
    do_write(32'h408, 32'h0BAD_BEEF, 3, 1'b1);
    do_read(32'h408, 2);

    // Random traffic over two sets and four tags to force hits and evictions.
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      a[18:9] = 10'($urandom_range(0, 3));
      a[8:3]  = 6'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      if (op == 0)      do_idle();
      else if (op <= 3) do_write(a, $urandom, $urandom_range(1, 4), op == 3);
      else              do_read(a, $urandom_range(1, 4));
    end
    do_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
